// File: rtl/flush_sequencer_pkg.sv
// Shared types and constants for the pipeline/cache flush sequencer.
package flush_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } flush_state_e;

   localparam int unsigned FLUSH_TGT_DCACHE = 0;
   localparam int unsigned FLUSH_TGT_ICACHE = 1;

   localparam logic [1:0] DEFAULT_FENCE_MASK  = 2'b01;
   localparam logic [1:0] DEFAULT_FENCEI_MASK = 2'b11;

endpackage

// File: rtl/flush_ack_tracker.sv
// Pending/queued flush-target bookkeeping, ack clearing and optional watchdog.
// The watchdog is built only when FLUSH_TIMEOUT_EN is defined.
module flush_ack_tracker
   import flush_sequencer_pkg::*;
#(
   parameter int unsigned NrFlushTgt = 2,
   parameter int unsigned AckTimeout = 1024
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wait_st,
   input  logic [NrFlushTgt-1:0] req_mask,
   input  logic [NrFlushTgt-1:0] ack,
   output logic [NrFlushTgt-1:0] pending,
   output logic                  done_c,
   output logic                  timeout_c
);

   logic [NrFlushTgt-1:0] pending_q;
   logic [NrFlushTgt-1:0] queued_q;
   logic [NrFlushTgt-1:0] pend_left;
   logic [NrFlushTgt-1:0] queue_all;
   logic                  timeout;

   assign pend_left = pending_q & ~ack;
   assign queue_all = queued_q | req_mask;

`ifdef FLUSH_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(AckTimeout);

   logic [CntW-1:0] cnt_q;

   // Cycles since WAIT entry or the last accepted ack.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else if (!wait_st || (|(ack & pending_q))) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CntW'(1);
      end
   end

   assign timeout = wait_st && (cnt_q == CntW'(AckTimeout - 1));
`else
   assign timeout = 1'b0;
`endif

   assign timeout_c = timeout;
   assign done_c    = wait_st && (timeout || ((pend_left == '0) && (queue_all == '0)));
   assign pending   = pending_q;

   // A queued fence is promoted the cycle the last pending bit retires.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q <= '0;
         queued_q  <= '0;
      end else if (!wait_st) begin
         pending_q <= req_mask;
         queued_q  <= '0;
      end else if (timeout) begin
         pending_q <= '0;
         queued_q  <= '0;
      end else if (pend_left == '0) begin
         pending_q <= queue_all;
         queued_q  <= '0;
      end else begin
         pending_q <= pend_left;
         queued_q  <= queue_all;
      end
   end

endmodule

// File: rtl/flush_sequencer.sv
// Pipeline flush strobe decode plus per-target cache/buffer flush sequencer.
// Optional ack watchdog: define FLUSH_TIMEOUT_EN.
module flush_sequencer
   import flush_sequencer_pkg::*;
#(
   parameter int unsigned          NrFlushTgt = 2,
   parameter logic [NrFlushTgt-1:0] FenceMask  = NrFlushTgt'(DEFAULT_FENCE_MASK),
   parameter logic [NrFlushTgt-1:0] FenceIMask = NrFlushTgt'(DEFAULT_FENCEI_MASK),
   parameter int unsigned          AckTimeout = 1024,
   parameter bit                   RVH        = 1'b1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  v_i,
   input  logic                  mispredict_i,
   input  logic                  fence_i,
   input  logic                  fence_i_i,
   input  logic                  sfence_vma_i,
   input  logic                  hfence_vvma_i,
   input  logic                  hfence_gvma_i,
   input  logic                  flush_csr_i,
   input  logic                  flush_commit_i,
   input  logic                  ex_valid_i,
   input  logic                  eret_i,
   input  logic                  set_debug_pc_i,
   input  logic                  halt_csr_i,
   output logic                  set_pc_commit_o,
   output logic                  flush_if_o,
   output logic                  flush_unissued_instr_o,
   output logic                  flush_id_o,
   output logic                  flush_ex_o,
   output logic                  flush_bp_o,
   output logic                  flush_icache_o,
   output logic                  flush_tlb_o,
   output logic                  flush_tlb_vvma_o,
   output logic                  flush_tlb_gvma_o,
   output logic [NrFlushTgt-1:0] flush_req_o,
   input  logic [NrFlushTgt-1:0] flush_ack_i,
   output logic                  halt_o,
   output logic                  busy_o,
   output logic                  flush_timeout_o
);

   flush_state_e          state_q, state_d;
   logic [NrFlushTgt-1:0] req_mask;
   logic                  wait_st;
   logic                  done;
   logic                  any_fence;
   logic                  exc;

   assign any_fence = fence_i | fence_i_i | sfence_vma_i | hfence_vvma_i | hfence_gvma_i
                    | flush_csr_i | flush_commit_i;
   assign exc       = ex_valid_i | eret_i | set_debug_pc_i;

   // Exceptions redirect via their own PC, so they suppress set_pc_commit.
   always_comb begin
      set_pc_commit_o        = 1'b0;
      flush_if_o             = 1'b0;
      flush_unissued_instr_o = 1'b0;
      flush_id_o             = 1'b0;
      flush_ex_o             = 1'b0;
      flush_bp_o             = 1'b0;
      flush_icache_o         = fence_i_i;
      flush_tlb_o            = sfence_vma_i & ~(RVH & v_i);
      flush_tlb_vvma_o       = RVH & ((sfence_vma_i & v_i) | hfence_vvma_i);
      flush_tlb_gvma_o       = RVH & hfence_gvma_i;
      if (mispredict_i) begin
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
      end
      if (any_fence) begin
         set_pc_commit_o        = 1'b1;
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
         flush_id_o             = 1'b1;
         flush_ex_o             = 1'b1;
      end
      if (exc) begin
         set_pc_commit_o        = 1'b0;
         flush_if_o             = 1'b1;
         flush_unissued_instr_o = 1'b1;
         flush_id_o             = 1'b1;
         flush_ex_o             = 1'b1;
         flush_bp_o             = 1'b1;
      end
   end

   assign req_mask = (fence_i ? FenceMask : '0) | (fence_i_i ? FenceIMask : '0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (req_mask != '0) state_d = WAIT;
         WAIT:    if (done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign wait_st = (state_q == WAIT);
   assign busy_o  = wait_st;
   assign halt_o  = halt_csr_i | wait_st;

   flush_ack_tracker #(
      .NrFlushTgt (NrFlushTgt),
      .AckTimeout (AckTimeout)
   ) u_tracker (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .wait_st   (wait_st),
      .req_mask  (req_mask),
      .ack       (flush_ack_i),
      .pending   (flush_req_o),
      .done_c    (done),
      .timeout_c (flush_timeout_o)
   );

endmodule
